// File: rtl/if_wb_bridge.sv
// if_wb_bridge: instruction-fetch responder for the PC generator's pc/ce
// interface. Turns each fetch into one Wishbone classic read cycle.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   cpu_ce_i         fetch enable from PC generator
//   cpu_addr_i       fetch address, sampled only when a cycle is issued
//   stall_i          pipeline stall vector; bit 1 holds the IF/ID register
//   flush_i          exception flush; aborts or discards a fetch in flight
//   cpu_data_o       instruction word to IF/ID (combinational)
//   stallreq_o       stall request to pipeline control (combinational)
//   wb_adr_o         Wishbone address (registered)
//   wb_dat_i         Wishbone read data
//   wb_ack_i         Wishbone acknowledge, only honoured while BUSY
//   wb_cyc_o         Wishbone cycle (registered)
//   wb_stb_o         Wishbone strobe, identical to wb_cyc_o
//   wb_we_o          tied low; this port only reads
//   wb_sel_o         byte selects, all-ones during a cycle
module if_wb_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_ce_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_FOR_STALL
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [ADDR_W-1:0]   adr_d;
    logic                cyc_d;
    logic [SEL_W-1:0]    sel_d;
    logic [DATA_W-1:0]   rd_buf;
    logic [DATA_W-1:0]   buf_d;
    logic                if_hold;

    // Only the IF/ID hold bit matters to this stage.
    logic [4:0]          stall_unused;

    assign if_hold      = stall_i[1];
    assign stall_unused = {stall_i[5:2], stall_i[0]};

    // Strobe is never separated from cycle: single-beat reads only.
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wb_adr_o <= '0;
            wb_cyc_o <= 1'b0;
            wb_sel_o <= '0;
            rd_buf   <= '0;
        end else begin
            state    <= state_d;
            wb_adr_o <= adr_d;
            wb_cyc_o <= cyc_d;
            wb_sel_o <= sel_d;
            rd_buf   <= buf_d;
        end
    end

    always_comb begin
        state_d = state;
        adr_d   = wb_adr_o;
        cyc_d   = wb_cyc_o;
        sel_d   = wb_sel_o;
        buf_d   = rd_buf;
        unique case (state)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_addr_i;
                    cyc_d   = 1'b1;
                    sel_d   = '1;
                    buf_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Flush beats ack: a word acked alongside
                // a flush belongs to a squashed fetch.
                if (flush_i) begin
                    adr_d   = '0;
                    cyc_d   = 1'b0;
                    sel_d   = '0;
                    buf_d   = '0;
                    state_d = IDLE;
                end else if (wb_ack_i) begin
                    adr_d   = '0;
                    cyc_d   = 1'b0;
                    sel_d   = '0;
                    buf_d   = wb_dat_i;
                    state_d = if_hold ? WAIT_FOR_STALL : IDLE;
                end
            end
            WAIT_FOR_STALL: begin
                if (flush_i) begin
                    buf_d   = '0;
                    state_d = IDLE;
                end else if (!if_hold) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (!rst && !flush_i) begin
            unique case (state)
                IDLE: begin
                    stallreq_o = cpu_ce_i;
                end
                BUSY: begin
                    // Forward the word on its ack cycle so
                    // IF/ID captures it without a bubble.
                    if (wb_ack_i) begin
                        cpu_data_o = wb_dat_i;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_wb_bridge.sv
// tb_if_wb_bridge: scoreboard bench for if_wb_bridge.
// Each fetch is planned as a transaction; the expected per-cycle view is queued.
module tb_if_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ce_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;

    always #5 clk = ~clk;

    if_wb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o)
    );

    typedef struct packed {
        logic        sreq;
        logic [31:0] data;
        logic        cyc;
        logic [31:0] adr;
        logic [3:0]  sel;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   ncyc = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] rw();
        return 32'($urandom);
    endfunction

    function automatic logic [5:0] rs6();
        return 6'($urandom);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h",
                     nm, ncyc, act, exp);
        end
    endtask

    // Monitor: every cycle that has a queued expectation is compared.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            ncyc++;
            chk("stallreq", 32'(stallreq_o), 32'(e.sreq));
            chk("cpu_data", cpu_data_o, e.data);
            chk("wb_cyc", 32'(wb_cyc_o), 32'(e.cyc));
            chk("wb_stb", 32'(wb_stb_o), 32'(e.cyc));
            chk("wb_adr", wb_adr_o, e.adr);
            chk("wb_sel", 32'(wb_sel_o), 32'(e.sel));
            chk("wb_we", 32'(wb_we_o), 32'd0);
        end
    end

    task automatic step(input logic r, input logic ce,
                        input logic [31:0] a, input logic [5:0] st,
                        input logic fl, input logic ak,
                        input logic [31:0] dt, input exp_t e);
        @(posedge clk);
        #1;
        rst        = r;
        cpu_ce_i   = ce;
        cpu_addr_i = a;
        stall_i    = st;
        flush_i    = fl;
        wb_ack_i   = ak;
        wb_dat_i   = dt;
        q.push_back(e);
    endtask

    // One fetch of word d from address a with n wait states.
    // w: cycles the word is held by stall (0 = released at ack).
    // fl_at / rs_at: BUSY cycle index of a flush / reset (-1 none).
    // wf_at: held-cycle index of a flush (-1 none).
    task automatic fetch(input logic [31:0] a, input int n, input int w,
                         input int fl_at, input int rs_at,
                         input int wf_at, input int gap,
                         input logic [31:0] d);
        exp_t       e;
        logic [5:0] st;
        bit         cut;
        cut = 0;
        e = '0;
        e.sreq = 1'b1;
        step(1'b0, 1'b1, a, rs6(), 1'b0, rb(), rw(), e);
        for (int j = 0; j <= n; j++) begin
            e = '0;
            e.cyc = 1'b1;
            e.adr = a;
            e.sel = 4'hF;
            if (rs_at == j) begin
                step(1'b1, rb(), rw(), rs6(), rb(), rb(), rw(), e);
                cut = 1;
                break;
            end
            if (fl_at == j) begin
                step(1'b0, rb(), rw(), rs6(), 1'b1, j == n, d, e);
                cut = 1;
                break;
            end
            if (j < n) begin
                e.sreq = 1'b1;
                step(1'b0, rb(), rw(), rs6(), 1'b0, 1'b0, rw(), e);
            end else begin
                e.data = d;
                st = rs6();
                st[1] = (w > 0);
                step(1'b0, rb(), rw(), st, 1'b0, 1'b1, d, e);
            end
        end
        if (!cut) begin
            for (int k = 0; k < w; k++) begin
                e = '0;
                st = rs6();
                if (wf_at == k) begin
                    step(1'b0, rb(), rw(), st, 1'b1, rb(), rw(), e);
                    break;
                end
                e.data = d;
                st[1] = (k < w - 1);
                step(1'b0, rb(), rw(), st, 1'b0, rb(), rw(), e);
            end
        end
        for (int g = 0; g < gap; g++) begin
            logic ce;
            ce = rb();
            e = '0;
            step(1'b0, ce, rw(), rs6(), ce ? 1'b1 : rb(), rb(), rw(), e);
        end
    endtask

    initial begin
        exp_t z;
        int   n, w, fl, rs, wf, gap;
        z = '0;
        step(1'b1, 1'b1, 32'h40, 6'h3F, 1'b0, 1'b1, 32'hDEAD_BEEF, z);
        step(1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 32'h0, z);

        fetch(32'h0000_0010, 0, 0, -1, -1, -1, 2, 32'h3C01_0001);
        fetch(32'h0000_0014, 3, 0, -1, -1, -1, 1, 32'h3421_0020);
        fetch(32'h0000_0018, 1, 3, -1, -1, -1, 0, 32'h1234_5678);
        fetch(32'h0000_001C, 0, 0, -1, -1, -1, 0, 32'h0BAD_F00D);
        fetch(32'h0000_0020, 3, 0, 1, -1, -1, 0, 32'hAAAA_5555);
        fetch(32'h0000_0024, 2, 0, 2, -1, -1, 1, 32'h5555_AAAA);
        fetch(32'h0000_0028, 3, 0, -1, 1, -1, 0, 32'hCAFE_0001);
        fetch(32'h0000_002C, 1, 0, -1, -1, -1, 1, 32'hCAFE_0002);
        fetch(32'h0000_0030, 0, 4, -1, -1, 1, 0, 32'hCAFE_0003);

        for (int i = 0; i < 400; i++) begin
            n   = int'($urandom_range(0, 4));
            w   = ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
            fl  = ($urandom % 6 == 0) ? int'($urandom_range(0, n)) : -1;
            rs  = (fl < 0 && $urandom % 10 == 0)
                  ? int'($urandom_range(0, n)) : -1;
            wf  = (w > 0 && $urandom % 4 == 0)
                  ? int'($urandom_range(0, w - 1)) : -1;
            gap = int'($urandom_range(0, 2));
            fetch(rw(), n, w, fl, rs, wf, gap, rw());
        end

        step(1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 32'h0, z);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/if_wb_bridge.md
# if_wb_bridge

Instruction-fetch bus bridge: the responder at the far end of the PC generator's `pc`/`ce` fetch interface. Each fetch address is turned into a single Wishbone classic read cycle, and the bridge requests a pipeline stall until the instruction word returns. The word is then handed to the IF/ID register, and held there while the pipeline is stalled. Sits between the PC generator / IF/ID register and the instruction-side Wishbone master port; `stall_i`/`flush_i` come from the pipeline control block.

## Interface
- `ADDR_W`, 32, byte-address width of `cpu_addr_i`/`wb_adr_o`
- `DATA_W`, 32, instruction word width; `wb_sel_o` width is DATA_W/8
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high; clock `clk`
- `cpu_ce_i`  in  1  fetch enable from PC generator
- `cpu_addr_i`  in  ADDR_W  fetch address (PC)
- `stall_i`  in  6  pipeline stall vector; bit 1 = IF/ID register held
- `flush_i`  in  1  exception flush; aborts/discards any fetch in flight
- `cpu_data_o`  out  DATA_W  instruction to IF/ID (combinational)
- `stallreq_o`  out  1  stall request to pipeline control (combinational)
- `wb_adr_o`  out  ADDR_W  Wishbone address (registered)
- `wb_dat_i`  in  DATA_W  Wishbone read data
- `wb_ack_i`  in  1  Wishbone acknowledge
- `wb_cyc_o`, `wb_stb_o`  out  1 each  cycle/strobe (registered, always equal)
- `wb_we_o`  out  1  constant 0 (read-only port)
- `wb_sel_o`  out  DATA_W/8  all-ones during a cycle, 0 otherwise (registered)

## Operation
- State register: IDLE, BUSY, WAIT_FOR_STALL. `rd_buf` (DATA_W) holds the returned word.
- **Reset:**
  - State IDLE.
  - `wb_adr_o`, `wb_cyc_o`, `wb_stb_o`, `wb_sel_o` and `rd_buf` all 0.
  - `cpu_data_o` and `stallreq_o` forced to 0 while `rst`=1.
- **IDLE:**
  - If `cpu_ce_i`=1 and `flush_i`=0: register `wb_adr_o`←`cpu_addr_i`, cyc=stb=1, sel=all-ones, clear `rd_buf`, go BUSY.
  - Otherwise remain in IDLE.
- **BUSY:**
  - `wb_ack_i`=1 and `flush_i`=0: drop cyc/stb/sel, `wb_adr_o`←0, `rd_buf`←`wb_dat_i`. Go WAIT_FOR_STALL if `stall_i[1]`=1, else IDLE.
  - `flush_i`=1 (with or without ack): drop cyc/stb/sel, `wb_adr_o`←0, `rd_buf`←0, go IDLE. Flush wins over ack; returned data is discarded.
  - Otherwise hold all bus outputs.
- **WAIT_FOR_STALL:**
  - `flush_i`=1: `rd_buf`←0, go IDLE.
  - `stall_i[1]`=0: go IDLE.
  - Otherwise hold.
- **Combinational outputs** (first match wins):
  - `flush_i`=1: stallreq=0, data=0.
  - IDLE with `cpu_ce_i`=1: stallreq=1, data=0.
  - IDLE with `cpu_ce_i`=0: stallreq=0, data=0.
  - BUSY with ack: stallreq=0, data=`wb_dat_i`.
  - BUSY without ack: stallreq=1, data=0.
  - WAIT_FOR_STALL: stallreq=0, data=`rd_buf`.
- No writes, no bursts, no error/retry handling; `wb_ack_i` outside BUSY is ignored.
- `cpu_addr_i` is sampled only at issue. Later changes do not affect a cycle in flight.

## Timing
- Issue: the edge after IDLE sees `cpu_ce_i`=1 asserts cyc/stb.
- Zero-wait slave (ack in the first BUSY cycle): instruction valid on `cpu_data_o` in cycle 2 of the fetch, so at most one instruction per 2 cycles.
- N wait states: `stallreq_o` high for N+1 cycles, data valid in cycle N+2.
- cyc/stb deassert on the edge after ack; never held more than one cycle past ack.
- Flush mid-cycle: cyc/stb low on the next edge; the next fetch may issue from IDLE one cycle later.
- Reset asserted mid-cycle: bus outputs 0 on the next edge regardless of ack.

## Test plan
- Zero-wait fetch:
  - Stimulus: ce=1, addr=0x00000010, slave acks in the first BUSY cycle with 0x3C010001.
  - Required: cyc/stb high for 1 cycle, `wb_adr_o`=0x10, `stallreq_o` pattern 1,0, `cpu_data_o`=0x3C010001 in cycle 2.
- Three wait states:
  - Stimulus: ack in the 4th BUSY cycle with 0x34210020.
  - Required: `stallreq_o` high 4 cycles, data appears on the ack cycle, cyc drops the following edge.
- Held by stall:
  - Stimulus: `stall_i`=6'b000011 at ack time, held 3 cycles, then 0.
  - Required: WAIT_FOR_STALL for 3 cycles with `cpu_data_o`=`rd_buf` constant and stallreq=0, then IDLE and the next fetch issues.
- Flush during BUSY:
  - Stimulus: flush pulse before ack; then flush and ack in the same cycle.
  - Required: cyc/stb/sel/adr=0 next edge, state IDLE, `cpu_data_o`=0, the acked word never reaches IF/ID.
- Reset mid-cycle:
  - Stimulus: rst=1 for 1 cycle while BUSY.
  - Required: all bus outputs and `rd_buf`=0 next edge, stallreq=0 during reset, and the fetch after reset completes normally.
